// File: rtl/edge_binarizer_if.sv
// Pixel stream and result bus for the edge binarizer.
// Handshake: valid-only stream with no backpressure. A pixel transfers on
// every rising clk edge where pixel_valid is high; a result transfers on
// every rising edge where out_valid is high. thr_load is a one-cycle write
// strobe for thr_in. frame_done is a one-cycle pulse that is coincident with
// out_valid for the last pixel of a frame.
interface edge_binarizer_if;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic [7:0]  thr_in;
  logic        thr_load;
  logic [7:0]  bin_out;
  logic        out_valid;
  logic [23:0] edge_count;
  logic [7:0]  frame_max;
  logic        frame_done;

  // Upstream side: produces pixels and threshold writes, consumes results.
  modport master (
    output pixel_in, pixel_valid, thr_in, thr_load,
    input  bin_out, out_valid, edge_count, frame_max, frame_done
  );

  // Binarizer side.
  modport slave (
    input  pixel_in, pixel_valid, thr_in, thr_load,
    output bin_out, out_valid, edge_count, frame_max, frame_done
  );
endinterface

// File: rtl/edge_binarizer.sv
// Thresholds an edge-magnitude stream into 0/255 pixels and gathers
// per-frame statistics (edge pixel count, peak magnitude). Threshold updates
// are double-buffered so a frame is always binarized with a single value.
module edge_binarizer #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int DEF_THR = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  edge_binarizer_if.slave  bus,
  output logic             fsm_state
);

  localparam int          FRAME_PIX   = (IMG_W - 2) * (IMG_H - 2);
  localparam logic [23:0] FRAME_PIX_W = 24'(FRAME_PIX);
  localparam logic [7:0]  DEF_THR_W   = 8'(DEF_THR);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [23:0] pix_cnt;
  logic [23:0] edge_acc;
  logic [7:0]  max_acc;
  logic [7:0]  act_thr;
  logic [7:0]  shd_thr;
  logic        pend;

  logic        accept;
  logic        is_edge;
  logic        last;
  logic        xfer;
  logic [23:0] cur_edges;
  logic [7:0]  cur_max;

  // Per-pixel decode: edge decision against the active threshold, frame end,
  // and the threshold transfer window (frame end or an idle, empty cycle).
  always_comb begin
    accept    = bus.pixel_valid;
    is_edge   = (bus.pixel_in >= act_thr);
    last      = accept && ((pix_cnt + 24'd1) == FRAME_PIX_W);
    xfer      = last || ((state == IDLE) && !accept);
    cur_edges = edge_acc + {23'd0, is_edge};
    cur_max   = (bus.pixel_in > max_acc) ? bus.pixel_in : max_acc;
  end

  // Next-state: a first pixel opens a frame unless it also closes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !last) state_nxt = RUN;
      RUN:     if (last)            state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pixel counter and running statistics for the frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= '0;
      edge_acc <= '0;
      max_acc  <= '0;
    end else if (last) begin
      pix_cnt  <= '0;
      edge_acc <= '0;
      max_acc  <= '0;
    end else if (accept) begin
      pix_cnt  <= pix_cnt + 24'd1;
      edge_acc <= cur_edges;
      max_acc  <= cur_max;
    end
  end

  // Shadow/active threshold pair. A write landing on a transfer cycle stays
  // pending, so the transfer moves the older shadow value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_thr <= DEF_THR_W;
      shd_thr <= DEF_THR_W;
      pend    <= 1'b0;
    end else begin
      if (xfer && pend) begin
        act_thr <= shd_thr;
        pend    <= 1'b0;
      end
      if (bus.thr_load) begin
        shd_thr <= bus.thr_in;
        pend    <= 1'b1;
      end
    end
  end

  // Registered pixel output; bin_out holds between valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bin_out   <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= accept;
      if (accept) bus.bin_out <= is_edge ? 8'd255 : 8'd0;
    end
  end

  // Frame results, latched with the final pixel included and held until the
  // next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.edge_count <= '0;
      bus.frame_max  <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= last;
      if (last) begin
        bus.edge_count <= cur_edges;
        bus.frame_max  <= cur_max;
      end
    end
  end

endmodule

// File: tb/tb_edge_binarizer.sv
// Randomized and directed stimulus for edge_binarizer on a 4x4 image
// (4 edge samples per frame). A reference model predicts every output pixel
// and frame result into queues; a negedge monitor pops and compares.
module tb_edge_binarizer;
  localparam int IMG_W     = 4;
  localparam int IMG_H     = 4;
  localparam int DEF_THR   = 64;
  localparam int FRAME_PIX = (IMG_W - 2) * (IMG_H - 2);

  logic clk;
  logic rst_n;
  logic fsm_state;

  edge_binarizer_if bif();

  edge_binarizer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DEF_THR(DEF_THR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];   // expected bin_out per accepted pixel
  logic [31:0] fexp_q[$];  // expected {edge_count, frame_max} per frame
  int          fd_cyc[$];  // monitor cycle index of each frame_done
  int chk_cnt  = 0;
  int pass_cnt = 0;
  int ov_cnt   = 0;
  int cyc_n    = 0;
  logic [23:0] hold_ec = '0;
  logic [7:0]  hold_fm = '0;

  // Reference model: a frame is just a list of pixel magnitudes; the
  // threshold is a value plus an optional pending replacement.
  int         m_cnt;
  int         m_edges;
  int         m_max;
  int         m_act;
  int         m_shadow;
  bit         m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_edges = 0; m_max = 0;
    m_act = DEF_THR; m_shadow = DEF_THR; m_pend = 0;
  endtask

  task automatic model_step(input bit v, input int p, input bit l, input int t);
    bit xf;
    xf = 0;
    if (v) begin
      exp_q.push_back((p >= m_act) ? 8'd255 : 8'd0);
      m_cnt++;
      if (p >= m_act) m_edges++;
      if (p > m_max) m_max = p;
      if (m_cnt == FRAME_PIX) begin
        fexp_q.push_back({m_edges[23:0], m_max[7:0]});
        m_cnt = 0; m_edges = 0; m_max = 0;
        xf = 1;
      end
    end else if (m_cnt == 0) begin
      xf = 1;
    end
    if (xf && m_pend) begin
      m_act = m_shadow;
      m_pend = 0;
    end
    if (l) begin
      m_shadow = t;
      m_pend = 1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit v, input logic [7:0] p, input bit l, input logic [7:0] t);
    bif.pixel_valid = v;
    bif.pixel_in    = p;
    bif.thr_load    = l;
    bif.thr_in      = t;
    model_step(v, int'(p), l, int'(t));
    @(posedge clk);
    #1;
    bif.pixel_valid = 1'b0;
    bif.thr_load    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom_range(0, 255)), 1'b0, 8'd0);
  endtask

  task automatic pix(input logic [7:0] p);
    cyc(1'b1, p, 1'b0, 8'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    hold_ec = '0;
    hold_fm = '0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.out_valid) begin
        ov_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexp_out: out_valid with bin_out=%0d and no pixel expected", bif.bin_out);
        end else begin
          check("bin_out", 32'(bif.bin_out), 32'(exp_q.pop_front()));
        end
      end
      if (bif.frame_done) begin
        fd_cyc.push_back(cyc_n);
        check("fd_with_ov", 32'(bif.out_valid), 32'd1);
        if (fexp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexp_frame_done: edge_count=%0d frame_max=%0d with no frame expected",
                   bif.edge_count, bif.frame_max);
        end else begin
          logic [31:0] f;
          f = fexp_q.pop_front();
          hold_ec = f[31:8];
          hold_fm = f[7:0];
          check("edge_count", 32'(bif.edge_count), 32'(hold_ec));
          check("frame_max", 32'(bif.frame_max), 32'(hold_fm));
        end
      end else begin
        check("ec_hold", 32'(bif.edge_count), 32'(hold_ec));
        check("fm_hold", 32'(bif.frame_max), 32'(hold_fm));
      end
      cyc_n++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int ov0;
    int fd0;
    bif.pixel_valid = 1'b0;
    bif.pixel_in    = 8'd0;
    bif.thr_load    = 1'b0;
    bif.thr_in      = 8'd0;
    rst_n           = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bin_out", 32'(bif.bin_out), 32'd0);
    check("rst_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_edge_count", 32'(bif.edge_count), 32'd0);
    check("rst_frame_max", 32'(bif.frame_max), 32'd0);
    check("rst_frame_done", 32'(bif.frame_done), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Basic frame at the default threshold, including the >= boundary.
    pix(8'd10); pix(8'd64); pix(8'd200); pix(8'd63);
    check("f1_edge_count", 32'(bif.edge_count), 32'd2);
    check("f1_frame_max", 32'(bif.frame_max), 32'd200);
    check("f1_frame_done", 32'(bif.frame_done), 32'd1);
    idle(2);

    // Threshold write mid-frame only takes effect on the following frame.
    pix(8'd100); pix(8'd63);
    cyc(1'b1, 8'd64, 1'b1, 8'd150);
    pix(8'd70);
    check("f2_edge_count", 32'(bif.edge_count), 32'd3);
    pix(8'd100); pix(8'd150); pix(8'd151); pix(8'd0);
    check("f3_edge_count", 32'(bif.edge_count), 32'd2);
    check("f3_frame_max", 32'(bif.frame_max), 32'd151);
    idle(1);

    // Same pixels with random gaps: out_valid for exactly 4 cycles.
    ov0 = ov_cnt;
    idle($urandom_range(0, 3)); pix(8'd100);
    idle($urandom_range(0, 3)); pix(8'd150);
    idle($urandom_range(0, 3)); pix(8'd151);
    idle($urandom_range(0, 3)); pix(8'd0);
    idle(2);
    check("gap_out_valid_cycles", 32'(ov_cnt - ov0), 32'd4);
    check("gap_edge_count", 32'(bif.edge_count), 32'd2);

    // Back-to-back frames with no dead cycle between them.
    fd0 = fd_cyc.size();
    for (int i = 0; i < 4; i++) pix(8'd255);
    for (int i = 0; i < 4; i++) pix(8'd0);
    idle(2);
    if (fd_cyc.size() == fd0 + 2) begin
      check("b2b_fd_spacing", 32'(fd_cyc[fd0 + 1] - fd_cyc[fd0]), 32'd4);
    end else begin
      chk_cnt++;
      $display("FAIL b2b_fd_count: got %0d frame_done pulses expected 2", fd_cyc.size() - fd0);
    end
    check("b2b_edge_count", 32'(bif.edge_count), 32'd0);

    // Reset in the middle of a frame abandons it.
    pix(8'd255); pix(8'd255);
    idle(1);
    do_reset(2);
    check("midrst_edge_count", 32'(bif.edge_count), 32'd0);
    idle(1);
    for (int i = 0; i < 4; i++) pix(8'd255);
    check("postrst_edge_count", 32'(bif.edge_count), 32'd4);
    check("postrst_frame_done", 32'(bif.frame_done), 32'd1);
    idle(1);

    // Write on the final-pixel cycle: old threshold for that pixel, new value
    // applied after the idle cycle that follows.
    pix(8'd10); pix(8'd10); pix(8'd10);
    cyc(1'b1, 8'd30, 1'b1, 8'd20);
    check("lastload_edge_count", 32'(bif.edge_count), 32'd0);
    idle(1);
    pix(8'd20); pix(8'd19); pix(8'd30); pix(8'd0);
    check("newthr_edge_count", 32'(bif.edge_count), 32'd2);
    idle(1);

    // Randomized traffic with sporadic threshold writes.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
    end
    // Finish any partial frame so every prediction is consumed.
    while (m_cnt != 0) pix(8'($urandom_range(0, 255)));
    idle(3);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("fexp_q_drained", 32'(fexp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/edge_binarizer.md
EDGE_BINARIZER -- requirements
Module: edge_binarizer

Interface
REQ-001 SHALL have parameter IMG_W, default 256, meaning input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 256, meaning input image height in pixels.
REQ-003 SHALL have parameter DEF_THR, default 64, meaning threshold value used after reset.
REQ-004 SHALL define localparam FRAME_PIX = (IMG_W-2)*(IMG_H-2), the number of valid edge samples per frame.
REQ-005 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port pixel_in  input  8  edge magnitude from the upstream edge filter.
REQ-008 SHALL have port pixel_valid  input  1  pixel_in is valid this cycle.
REQ-009 SHALL have port thr_in  input  8  new threshold value.
REQ-010 SHALL have port thr_load  input  1  capture thr_in into the shadow threshold.
REQ-011 SHALL have port bin_out  output  8  binarized pixel, 8'd255 for an edge and 8'd0 otherwise.
REQ-012 SHALL have port out_valid  output  1  bin_out is valid.
REQ-013 SHALL have port edge_count  output  24  number of edge pixels in the last completed frame.
REQ-014 SHALL have port frame_max  output  8  maximum pixel_in seen in the last completed frame.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse that fires when a frame completes.

Function
REQ-016 SHALL run a 2-state FSM: IDLE (no frame in progress) and RUN (frame in progress).
REQ-017 SHALL transition IDLE->RUN on pixel_valid, except when FRAME_PIX==1, where it SHALL stay in IDLE.
REQ-018 SHALL transition RUN->IDLE on the pixel_valid that makes the accepted count equal FRAME_PIX; in all other cases it SHALL hold state.
REQ-019 SHALL count accepted pixels in a 24-bit pix_cnt, clear it to 0 on frame completion, and ignore cycles with pixel_valid low.
REQ-020 SHALL classify a pixel as an edge when pixel_in >= active threshold, using an unsigned 8-bit compare.
REQ-021 SHALL register bin_out and out_valid one cycle after the pixel_valid that produced them (latency 1); out_valid SHALL be 0 on cycles following pixel_valid low, with bin_out holding its value.
REQ-022 SHALL write thr_in to a shadow register with a pending flag set on the cycle thr_load is high; if thr_load repeats, the last write wins.
REQ-023 SHALL copy the shadow value to the active threshold and clear pending on the frame-completion cycle, or on any IDLE cycle with pixel_valid low.
REQ-024 SHALL never change the active threshold mid-frame; a pixel accepted on the same cycle as a threshold transfer SHALL use the old active value.
REQ-025 SHALL, when thr_load coincides with a transfer cycle, transfer the previous shadow value and keep the new thr_in pending.
REQ-026 SHALL maintain a running 24-bit edge accumulator and an 8-bit running maximum, both including the current accepted pixel.
REQ-027 SHALL, on frame completion: latch edge_count and frame_max with values that include the final pixel, pulse frame_done in the same cycle that out_valid is high for the final pixel, and clear the accumulators.
REQ-028 SHALL start a new frame with the pixel_valid on the cycle immediately after completion, with no dead cycle.
REQ-029 SHALL hold edge_count and frame_max stable between frame_done pulses.

Reset
REQ-030 SHALL, while rst_n is low: state=IDLE, pix_cnt=0, accumulators=0, active and shadow threshold=DEF_THR, pending=0, bin_out=0, out_valid=0, edge_count=0, frame_max=0, frame_done=0.
REQ-031 SHALL, on reset assertion mid-frame, abandon the partial frame with no frame_done; counting SHALL restart from the first pixel_valid after release.

Verification (IMG_W=4, IMG_H=4, FRAME_PIX=4, DEF_THR=64)
REQ-032 SHALL verify: pixels 10,64,200,63 -> bin_out 0,255,255,0 each one cycle later; frame_done with the 4th output; edge_count=2; frame_max=200.
REQ-033 SHALL verify: thr_in=150 with thr_load after pixel 2 of a frame -> that frame still uses 64; the next frame, given 100,150,151,0, gives edge_count=2.
REQ-034 SHALL verify: the same 4 pixels with pixel_valid gaps of 0-3 cycles -> identical outputs, and out_valid is asserted for exactly 4 cycles.
REQ-035 SHALL verify: two back-to-back frames of 255s then 0s -> frame_done pulses exactly 4 cycles apart; edge_count is 4 then 0; frame_max is 255 then 0.
REQ-036 SHALL verify: rst_n low after 2 pixels, then 4 pixels of 255 -> no frame_done before the 4th post-reset pixel; edge_count=4 after it.
REQ-037 SHALL verify: thr_load with thr_in=20 on the final-pixel cycle -> the final pixel uses the old threshold; the following frame uses 20.
